sccb_responder: RTL and testbench
=================================

Name: sccb_responder

Overview:
- SCCB slave (camera emulator) answering the OV7670 configuration master on the same two-wire bus.
- Oversamples SIOC/SIOD on the system clock.
- Decodes 3-phase writes into a 256x8 register file and serves 2-phase reads.
- Used for on-board loopback of the config flow: config master drives the bus, this block captures what the camera would see and lets logic/ILA inspect it.

Parameters:
- DEVICE_ID, 8'h42, write ID; read ID is DEVICE_ID|1 (8'h43).
- ACK_EN, 1, 1 = drive ACK low on the 9th bit of ID/sub-address/write-data phases; 0 = leave the bus released (SCCB don't-care).
- PID_VAL, 8'h76, fixed reset contents of register 0x0A.
- VER_VAL, 8'h73, fixed reset contents of register 0x0B.
- RO_PROTECT, 1, 1 = writes to 0x0A/0x0B are acked but not stored and not strobed.

Ports:
- clk  in  1  system clock; must be at least 8x the SIOC frequency.
- rst_n  in  1  synchronous, active-low reset.
- sioc  in  1  SCCB clock from the master (asynchronous).
- siod_in  in  1  SCCB data pin as seen on the bus (asynchronous).
- siod_oe  out  1  1 = pull SIOD low (open-drain); 0 = release.
- wr_strobe  out  1  1-cycle pulse when a register write commits.
- wr_addr  out  8  sub-address of the committed write; valid with wr_strobe.
- wr_data  out  8  data of the committed write; valid with wr_strobe.
- busy  out  1  high between an accepted START and the next STOP.
- peek_addr  in  8  side-band register read address.
- peek_data  out  8  reg[peek_addr], registered (1-cycle latency).

Behaviour:
- Input conditioning:
  - 2-flop synchronizers on sioc and siod_in, then a 1-flop delay for edge detection.
  - Bus events are seen 3 clk after the pin change.
- Bus events:
  - START = SIOD falls while SIOC high.
  - STOP = SIOD rises while SIOC high.
  - Bits are sampled on SIOC rising edges, MSB first.
  - The slave changes siod_oe only on the clk after an SIOC falling edge.
- Reset values:
  - siod_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, peek_data=0.
  - State IDLE, sub-address pointer 0.
  - All registers 0x00 except reg[0x0A]=PID_VAL and reg[0x0B]=VER_VAL.
- FSM states: IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NA, IGNORE.
  - IDLE: START -> ID, busy=1.
  - ID: after 8 bits, compare the byte:
    - DEVICE_ID -> ID_ACK with dir=write.
    - DEVICE_ID|1 -> ID_ACK with dir=read.
    - Otherwise -> IGNORE; siod_oe stays 0.
  - ID_ACK: siod_oe=ACK_EN from the falling edge after bit 8 until the falling edge after bit 9. Then go to SUB (write) or RDATA (read; load shifter with reg[pointer]).
  - SUB: 8 bits -> latch pointer -> SUB_ACK -> WDATA.
  - WDATA: 8 bits -> commit -> WDATA_ACK -> IGNORE (extra bytes are not stored).
    - Commit: write reg[pointer], assert wr_strobe for 1 clk with wr_addr/wr_data, subject to RO_PROTECT.
  - RDATA: drive 8 bits MSB first; siod_oe = ~bit, updated after each SIOC falling edge.
    - The first bit is driven after the falling edge that ends the ID ack bit.
  - RDATA_NA: release; sample the master's 9th bit (NA expected) and ignore its value -> IGNORE.
  - IGNORE: wait, bus released.
- Overriding events:
  - STOP in any state -> IDLE, siod_oe=0, busy=0. The pointer is retained, so a 2-phase write followed by STOP sets the read address.
  - START in any state (repeated start) -> ID, bit counter cleared, siod_oe=0. A partial byte is discarded and no write is committed.
- No pointer auto-increment.
- A read with no prior sub-address phase returns reg[0x00].
- A write and a peek to the same address in the same clk: peek_data shows the old value; the new value appears on the next peek cycle.
- rst_n low mid-transfer: immediate return to IDLE, bus released, register file re-initialised. The master sees a missing ACK / all-ones read.

Decomposition:
- Shared package holds:
  - State enum.
  - SCCB_ID_WR/SCCB_ID_RD constants.
  - Fixed-register addresses REG_PID=8'h0A, REG_VER=8'h0B.
- One natural sub-module: sccb_bus_sync. It holds the synchronizers and edge detect, and outputs scl_rise, scl_fall, start_det, stop_det, sda_s.
- The register file stays inline.

Test Plan:
- 3-phase write 42/12/80 with ACK_EN=1:
  - ACK low seen in all three 9th bits.
  - One wr_strobe with wr_addr=0x12, wr_data=0x80.
  - peek_addr=0x12 -> peek_data=0x80.
- 2-phase write 42/0A, STOP, then 2-phase read 43:
  - Master samples 0x76 on SIOD.
  - siod_oe=0 during the NA bit; busy drops 3 clk after STOP.
- Wrong ID 0x60 then 12/55:
  - siod_oe never asserted; no wr_strobe; reg[0x12] unchanged.
- Repeated START after the 4th data bit of 42/20/xx, then full 42/20/3C:
  - Exactly one wr_strobe, with data 0x3C.
- RO_PROTECT=1, write 42/0B/FF:
  - ACKed, no wr_strobe, peek 0x0B = 0x73.
- rst_n low for 1 clk during the SUB phase:
  - siod_oe=0 on the next clk, busy=0.
  - A following write 42/01/AA completes normally.

Source files
------------

// File: rtl/sccb_responder_pkg.sv
// -----------------------------------------------------------------------------
// sccb_responder_pkg
// Shared definitions for the SCCB responder (OV7670 camera emulator):
//   - state_e          : protocol FSM states
//   - SCCB_ID_WR/RD    : default 8-bit write/read device IDs
//   - REG_PID/REG_VER  : addresses of the fixed identification registers
//   - reg_reset_value  : power-on contents of one register-file entry
//   - is_id_reg        : true for the two identification registers
// -----------------------------------------------------------------------------
package sccb_responder_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_ID_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_NA,
        ST_IGNORE
    } state_e;

    localparam logic [7:0] SCCB_ID_WR = 8'h42;
    localparam logic [7:0] SCCB_ID_RD = SCCB_ID_WR | 8'h01;

    localparam logic [7:0] REG_PID = 8'h0A;
    localparam logic [7:0] REG_VER = 8'h0B;

    // Everything powers up as 0x00 except the two identification registers.
    function automatic logic [7:0] reg_reset_value(
        input logic [7:0] addr,
        input logic [7:0] pid,
        input logic [7:0] ver
    );
        logic [7:0] val;
        val = 8'h00;
        if (addr == REG_PID) val = pid;
        if (addr == REG_VER) val = ver;
        return val;
    endfunction

    function automatic logic is_id_reg(input logic [7:0] addr);
        return (addr == REG_PID) || (addr == REG_VER);
    endfunction

endpackage : sccb_responder_pkg

// File: rtl/sccb_bus_sync.sv
// -----------------------------------------------------------------------------
// sccb_bus_sync
// Brings the asynchronous SIOC/SIOD pins into the clk domain and derives the
// bus events. Each pin goes through a 2-flop synchronizer followed by a
// 1-flop delay; events are combinational on (synchronized, delayed) pairs, so
// the registered consumer reacts 3 clk after the pin change.
//
// Ports:
//   clk        in   system clock (>= 8x SIOC)
//   rst_n      in   synchronous active-low reset
//   sioc       in   raw SCCB clock pin
//   siod_in    in   raw SCCB data pin
//   scl_rise   out  1-cycle pulse: SIOC rose (bit sample point)
//   scl_fall   out  1-cycle pulse: SIOC fell (slave may change SIOD)
//   start_det  out  1-cycle pulse: SIOD fell while SIOC high
//   stop_det   out  1-cycle pulse: SIOD rose while SIOC high
//   sda_s      out  synchronized SIOD level
// -----------------------------------------------------------------------------
module sccb_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sioc,
    input  logic siod_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_dly_q;
    logic       sda_dly_q;
    logic       scl_s;

    // Reset to the idle-bus level (both lines high) so that leaving reset on a
    // quiet bus never manufactures a START or STOP.
    // NOTE: every flop here is written with <= so all stages sample the value
    // from before the edge; blocking assignments would collapse the chain into
    // a single stage and defeat the synchronizer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], sioc};
            sda_sync_q <= {sda_sync_q[0], siod_in};
            scl_dly_q  <= scl_sync_q[1];
            sda_dly_q  <= sda_sync_q[1];
        end
    end

    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];

    assign scl_rise = scl_s & ~scl_dly_q;
    assign scl_fall = ~scl_s & scl_dly_q;

    // SIOC must be high in both samples, so a data change that lands in the
    // same cycle as an SIOC edge is never mistaken for START/STOP.
    assign start_det = scl_s & scl_dly_q &  sda_dly_q & ~sda_s;
    assign stop_det  = scl_s & scl_dly_q & ~sda_dly_q &  sda_s;

endmodule : sccb_bus_sync

// File: rtl/sccb_responder.sv
// -----------------------------------------------------------------------------
// sccb_responder
// SCCB slave emulating the OV7670 configuration port. Decodes 3-phase writes
// (ID, sub-address, data) into a 256x8 register file and answers 2-phase reads
// (ID, data) from the last latched sub-address. Used for on-board loopback of
// a configuration master: the written values can be watched on the wr_* strobe
// or inspected through the side-band peek port.
//
// Ports:
//   clk        in   system clock (>= 8x SIOC)
//   rst_n      in   synchronous active-low reset; also re-initialises registers
//   sioc       in   SCCB clock from the master (asynchronous)
//   siod_in    in   SCCB data as seen on the bus (asynchronous)
//   siod_oe    out  1 = pull SIOD low (open-drain), 0 = release
//   wr_strobe  out  1-cycle pulse when a register write commits
//   wr_addr    out  address of the committed write (valid with wr_strobe)
//   wr_data    out  data of the committed write (valid with wr_strobe)
//   busy       out  high from an accepted START until the next STOP
//   peek_addr  in   side-band read address
//   peek_data  out  reg[peek_addr], one cycle of latency
// -----------------------------------------------------------------------------
module sccb_responder
    import sccb_responder_pkg::*;
#(
    parameter logic [7:0] DEVICE_ID  = SCCB_ID_WR,
    parameter bit         ACK_EN     = 1'b1,
    parameter logic [7:0] PID_VAL    = 8'h76,
    parameter logic [7:0] VER_VAL    = 8'h73,
    parameter bit         RO_PROTECT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sioc,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    input  logic [7:0] peek_addr,
    output logic [7:0] peek_data
);

    localparam logic [7:0] READ_ID = DEVICE_ID | 8'h01;

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    sccb_bus_sync u_bus_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sioc      (sioc),
        .siod_in   (siod_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       dir_rd_q, dir_rd_d;
    logic [7:0] ptr_q, ptr_d;
    logic       siod_oe_q, siod_oe_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] peek_data_q;
    logic [7:0] regs_q [256];

    logic       reg_we;
    logic [7:0] rx_byte;
    logic [7:0] rd_byte;

    assign rx_byte = {shift_q[6:0], sda_s};
    assign rd_byte = regs_q[ptr_q];

    // -------------------------------------------------------------------------
    // Next-state / output logic.
    // Ack bits use bit_cnt as a 3-step sequencer:
    //   0 -> (SIOC fall) drive ACK -> 1 -> (SIOC rise, 9th bit) -> 2
    //   2 -> (SIOC fall) release and move on.
    // In RDATA, bit_cnt counts the bits the master has already sampled.
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned below gets its default first, so no path
    // leaves one unassigned and no latch can be inferred.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        dir_rd_d    = dir_rd_q;
        ptr_d       = ptr_q;
        siod_oe_d   = siod_oe_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        reg_we      = 1'b0;

        if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            siod_oe_d = 1'b0;
        end else if (start_det) begin
            // Also covers repeated START: any partial byte is dropped.
            state_d   = ST_ID;
            bit_cnt_d = '0;
            siod_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;

                ST_ID: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            if (rx_byte == DEVICE_ID) begin
                                dir_rd_d = 1'b0;
                                state_d  = ST_ID_ACK;
                            end else if (rx_byte == READ_ID) begin
                                dir_rd_d = 1'b1;
                                state_d  = ST_ID_ACK;
                            end else begin
                                state_d  = ST_IGNORE;
                            end
                        end
                    end
                end

                ST_SUB: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            ptr_d     = rx_byte;
                            state_d   = ST_SUB_ACK;
                        end
                    end
                end

                ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            state_d   = ST_WDATA_ACK;
                            // Protected ID registers are acked but untouched.
                            if (!(RO_PROTECT && is_id_reg(ptr_q))) begin
                                reg_we      = 1'b1;
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = ptr_q;
                                wr_data_d   = rx_byte;
                            end
                        end
                    end
                end

                ST_ID_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
                    if (scl_fall && bit_cnt_q == 4'd0) begin
                        siod_oe_d = ACK_EN;
                        bit_cnt_d = 4'd1;
                    end else if (scl_rise && bit_cnt_q == 4'd1) begin
                        bit_cnt_d = 4'd2;
                    end else if (scl_fall && bit_cnt_q == 4'd2) begin
                        siod_oe_d = 1'b0;
                        bit_cnt_d = '0;
                        if (state_q == ST_ID_ACK) begin
                            if (dir_rd_q) begin
                                // First read bit goes out on this same fall.
                                state_d   = ST_RDATA;
                                shift_d   = rd_byte;
                                siod_oe_d = ~rd_byte[7];
                            end else begin
                                state_d   = ST_SUB;
                            end
                        end else if (state_q == ST_SUB_ACK) begin
                            state_d = ST_WDATA;
                        end else begin
                            // Bytes beyond the first data byte are not stored.
                            state_d = ST_IGNORE;
                        end
                    end
                end

                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = ST_RDATA_NA;
                            bit_cnt_d = '0;
                            siod_oe_d = 1'b0;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            siod_oe_d = ~shift_q[6];
                        end
                    end
                end

                // The master's NA/ACK value is irrelevant: one sample, then wait.
                ST_RDATA_NA: begin
                    if (scl_rise) state_d = ST_IGNORE;
                end

                ST_IGNORE: ;

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            dir_rd_q    <= 1'b0;
            ptr_q       <= '0;
            siod_oe_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            dir_rd_q    <= dir_rd_d;
            ptr_q       <= ptr_d;
            siod_oe_q   <= siod_oe_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // -------------------------------------------------------------------------
    // Register file and peek port. A peek of the address being written in the
    // same cycle returns the old contents.
    // -------------------------------------------------------------------------
    // NOTE: this memory is deliberately reset: a reset must restore the camera's
    // power-on register image, which rules out a RAM macro.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) begin
                regs_q[i] <= reg_reset_value(8'(i), PID_VAL, VER_VAL);
            end
            peek_data_q <= '0;
        end else begin
            if (reg_we) regs_q[ptr_q] <= rx_byte;
            peek_data_q <= regs_q[peek_addr];
        end
    end

    assign siod_oe   = siod_oe_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign peek_data = peek_data_q;

endmodule : sccb_responder

// File: tb/tb_sccb_responder.sv
// -----------------------------------------------------------------------------
// tb_sccb_responder
// Bit-level SCCB master driving the responder over a wired-AND SIOD, with a
// behavioural model (register image + sub-address pointer) derived from the
// bus protocol rules. SIOC period is 16 clk; pins change 1 time unit after a
// clk rising edge.
// -----------------------------------------------------------------------------
module tb_sccb_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       siod_bus;
    logic       siod_oe;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [7:0] peek_addr = 8'h00;
    logic [7:0] peek_data;

    assign siod_bus = m_sda & ~siod_oe;

    always #5 clk = ~clk;

    sccb_responder #(
        .DEVICE_ID  (8'h42),
        .ACK_EN     (1'b1),
        .PID_VAL    (8'h76),
        .VER_VAL    (8'h73),
        .RO_PROTECT (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sioc      (m_scl),
        .siod_in   (siod_bus),
        .siod_oe   (siod_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .peek_addr (peek_addr),
        .peek_data (peek_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what a camera would hold after the transfers so far.
    logic [7:0]  mem [256];
    logic [7:0]  m_ptr;

    // Observed commits and SIOD-drive activity.
    logic [15:0] strobe_q [$];
    int          oe_hi_cycles = 0;

    always @(negedge clk) begin
        if (wr_strobe) strobe_q.push_back({wr_addr, wr_data});
        if (siod_oe) oe_hi_cycles++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // ---------------------------------------------------------------- model
    task automatic model_reset();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h0A] = 8'h76;
        mem[8'h0B] = 8'h73;
        m_ptr = 8'h00;
    endtask

    // --------------------------------------------------------- bus helpers
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [7:0] a, output logic [7:0] d);
        peek_addr = a;
        wait_clk(2);
        d = peek_data;
    endtask

    // Works from idle (SIOC high) and as a repeated START (SIOC low).
    task automatic bus_start();
        m_sda = 1'b1; wait_clk(4);
        m_scl = 1'b1; wait_clk(8);
        m_sda = 1'b0; wait_clk(8);
        m_scl = 1'b0; wait_clk(4);
    endtask

    // Returns busy 2 and 3 clk after SIOD rises.
    task automatic bus_stop(output logic b2, output logic b3);
        m_sda = 1'b0; wait_clk(4);
        m_scl = 1'b1; wait_clk(8);
        m_sda = 1'b1; wait_clk(2);
        b2 = busy;    wait_clk(1);
        b3 = busy;    wait_clk(8);
    endtask

    task automatic bus_bit(input logic b, output logic smp, output logic oe_s);
        m_sda = b;    wait_clk(4);
        m_scl = 1'b1; wait_clk(4);
        smp  = siod_bus;
        oe_s = siod_oe;
        wait_clk(4);
        m_scl = 1'b0; wait_clk(4);
    endtask

    // 8 bits of tx then a released 9th bit; returns bus samples.
    task automatic bus_byte(input logic [7:0] tx, output logic [7:0] rx,
                            output logic ack, output logic ack_oe);
        logic s, o;
        rx = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(tx[i], s, o);
            rx[i] = s;
        end
        bus_bit(1'b1, ack, ack_oe);
    endtask

    task automatic sccb_write3(input logic [7:0] a, input logic [7:0] d,
                               output logic [2:0] acks);
        logic [7:0] rx;
        logic o, b2, b3;
        bus_start();
        bus_byte(8'h42, rx, acks[2], o);
        bus_byte(a,     rx, acks[1], o);
        bus_byte(d,     rx, acks[0], o);
        bus_stop(b2, b3);
    endtask

    task automatic sccb_write2(input logic [7:0] a, output logic [1:0] acks,
                               output logic b2, output logic b3);
        logic [7:0] rx;
        logic o;
        bus_start();
        bus_byte(8'h42, rx, acks[1], o);
        bus_byte(a,     rx, acks[0], o);
        bus_stop(b2, b3);
    endtask

    task automatic sccb_read(output logic [7:0] data, output logic id_ack,
                             output logic na_oe);
        logic [7:0] rx;
        logic o, na, b2, b3;
        bus_start();
        bus_byte(8'h43, rx, id_ack, o);
        bus_byte(8'hFF, data, na, na_oe);
        bus_stop(b2, b3);
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        logic [7:0] d;
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        model_reset();
        wait_clk(1);
        n_tests++;
        if ({siod_oe, wr_strobe, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got oe/strobe/busy=%b expected 000", {siod_oe, wr_strobe, busy});
        end
        n_tests++;
        if ({wr_addr, wr_data, peek_data} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h data=%h peek=%h expected all 00", wr_addr, wr_data, peek_data);
        end
        peek(8'h0A, d);
        n_tests++;
        if (d !== 8'h76) begin n_fail++; $display("FAIL reset_pid: got %h expected 76", d); end
        peek(8'h0B, d);
        n_tests++;
        if (d !== 8'h73) begin n_fail++; $display("FAIL reset_ver: got %h expected 73", d); end
    endtask

    task automatic test_write3();
        logic [2:0] acks;
        logic [7:0] d;
        strobe_q.delete();
        sccb_write3(8'h12, 8'h80, acks);
        m_ptr = 8'h12;
        mem[8'h12] = 8'h80;
        n_tests++;
        if (acks !== 3'b000) begin n_fail++; $display("FAIL write3_acks: got %b expected 000", acks); end
        n_tests++;
        if (strobe_q.size() != 1) begin
            n_fail++; $display("FAIL write3_strobe_count: got %0d expected 1", strobe_q.size());
        end else begin
            n_tests++;
            if (strobe_q[0] !== 16'h1280) begin
                n_fail++; $display("FAIL write3_strobe: got %h expected 1280", strobe_q[0]);
            end
        end
        peek(8'h12, d);
        n_tests++;
        if (d !== 8'h80) begin n_fail++; $display("FAIL write3_peek: got %h expected 80", d); end
    endtask

    task automatic test_read_pid();
        logic [1:0] acks;
        logic       b2, b3, id_ack, na_oe;
        logic [7:0] d;
        sccb_write2(8'h0A, acks, b2, b3);
        m_ptr = 8'h0A;
        n_tests++;
        if (acks !== 2'b00) begin n_fail++; $display("FAIL read_setptr_acks: got %b expected 00", acks); end
        n_tests++;
        if ({b2, b3} !== 2'b10) begin
            n_fail++; $display("FAIL stop_busy_timing: busy at +2/+3 clk got %b expected 10", {b2, b3});
        end
        sccb_read(d, id_ack, na_oe);
        n_tests++;
        if (id_ack !== 1'b0) begin n_fail++; $display("FAIL read_id_ack: got %b expected 0", id_ack); end
        n_tests++;
        if (d !== mem[m_ptr]) begin n_fail++; $display("FAIL read_pid: got %h expected %h", d, mem[m_ptr]); end
        n_tests++;
        if (na_oe !== 1'b0) begin n_fail++; $display("FAIL read_na_release: siod_oe got %b expected 0", na_oe); end
    endtask

    task automatic test_wrong_id();
        logic [7:0] rx, d;
        logic [2:0] acks;
        logic       o, b2, b3;
        strobe_q.delete();
        oe_hi_cycles = 0;
        bus_start();
        bus_byte(8'h60, rx, acks[2], o);
        bus_byte(8'h12, rx, acks[1], o);
        bus_byte(8'h55, rx, acks[0], o);
        bus_stop(b2, b3);
        n_tests++;
        if (oe_hi_cycles != 0) begin n_fail++; $display("FAIL wrong_id_oe: got %0d driven cycles expected 0", oe_hi_cycles); end
        n_tests++;
        if (acks !== 3'b111) begin n_fail++; $display("FAIL wrong_id_acks: got %b expected 111", acks); end
        n_tests++;
        if (strobe_q.size() != 0) begin n_fail++; $display("FAIL wrong_id_strobe: got %0d expected 0", strobe_q.size()); end
        peek(8'h12, d);
        n_tests++;
        if (d !== mem[8'h12]) begin n_fail++; $display("FAIL wrong_id_reg: got %h expected %h", d, mem[8'h12]); end
    endtask

    task automatic test_repeated_start();
        logic [7:0] rx, d;
        logic [2:0] acks;
        logic       s, o;
        strobe_q.delete();
        bus_start();
        bus_byte(8'h42, rx, acks[2], o);
        bus_byte(8'h20, rx, acks[1], o);
        for (int i = 7; i >= 4; i--) bus_bit(i[0], s, o);
        m_ptr = 8'h20;
        sccb_write3(8'h20, 8'h3C, acks);
        mem[8'h20] = 8'h3C;
        n_tests++;
        if (strobe_q.size() != 1) begin
            n_fail++; $display("FAIL rstart_strobe_count: got %0d expected 1", strobe_q.size());
        end else begin
            n_tests++;
            if (strobe_q[0] !== 16'h203C) begin
                n_fail++; $display("FAIL rstart_strobe: got %h expected 203c", strobe_q[0]);
            end
        end
        peek(8'h20, d);
        n_tests++;
        if (d !== 8'h3C) begin n_fail++; $display("FAIL rstart_peek: got %h expected 3c", d); end
    endtask

    task automatic test_ro_protect();
        logic [2:0] acks;
        logic [7:0] d;
        strobe_q.delete();
        sccb_write3(8'h0B, 8'hFF, acks);
        m_ptr = 8'h0B;
        n_tests++;
        if (acks !== 3'b000) begin n_fail++; $display("FAIL ro_acks: got %b expected 000", acks); end
        n_tests++;
        if (strobe_q.size() != 0) begin n_fail++; $display("FAIL ro_strobe: got %0d expected 0", strobe_q.size()); end
        peek(8'h0B, d);
        n_tests++;
        if (d !== 8'h73) begin n_fail++; $display("FAIL ro_peek: got %h expected 73", d); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx, d;
        logic [2:0] acks;
        logic       s, o, id_ack, na_oe;
        logic [7:0] sub;
        sub = 8'h33;
        bus_start();
        bus_byte(8'h42, rx, acks[2], o);
        for (int i = 7; i >= 0; i--) bus_bit(sub[i], s, o);
        // Inside the sub-address ack bit, SIOC low: responder is acking.
        m_sda = 1'b1;
        n_tests++;
        if (siod_oe !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_ack: siod_oe got %b expected 1", siod_oe); end
        rst_n = 1'b0;
        wait_clk(1);
        n_tests++;
        if ({siod_oe, busy} !== 2'b00) begin
            n_fail++; $display("FAIL rst_mid_release: oe/busy got %b expected 00", {siod_oe, busy});
        end
        rst_n = 1'b1;
        model_reset();
        m_scl = 1'b1;
        wait_clk(8);
        peek(8'h12, d);
        n_tests++;
        if (d !== mem[8'h12]) begin n_fail++; $display("FAIL rst_mid_reinit: got %h expected %h", d, mem[8'h12]); end
        // Pointer is back to 0 with no sub-address phase since reset.
        sccb_read(d, id_ack, na_oe);
        n_tests++;
        if (d !== mem[8'h00]) begin n_fail++; $display("FAIL rst_mid_read0: got %h expected %h", d, mem[8'h00]); end
        strobe_q.delete();
        sccb_write3(8'h01, 8'hAA, acks);
        m_ptr = 8'h01;
        mem[8'h01] = 8'hAA;
        n_tests++;
        if (acks !== 3'b000) begin n_fail++; $display("FAIL rst_mid_acks: got %b expected 000", acks); end
        n_tests++;
        if (strobe_q.size() != 1 || strobe_q[0] !== 16'h01AA) begin
            n_fail++; $display("FAIL rst_mid_write: got %0d strobes expected one 01aa", strobe_q.size());
        end
        peek(8'h01, d);
        n_tests++;
        if (d !== 8'hAA) begin n_fail++; $display("FAIL rst_mid_peek: got %h expected aa", d); end
    endtask

    task automatic test_random();
        logic [7:0] a, d, got;
        logic [2:0] acks;
        logic [1:0] acks2;
        logic       b2, b3, id_ack, na_oe, prot;
        int         op, exp_n;
        for (int it = 0; it < 24; it++) begin
            op = $urandom_range(0, 3);
            a  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) a = 8'h0A | 8'($urandom_range(0, 1));
            d  = 8'($urandom_range(0, 255));
            case (op)
                0: begin
                    strobe_q.delete();
                    sccb_write3(a, d, acks);
                    m_ptr = a;
                    prot  = (a == 8'h0A) || (a == 8'h0B);
                    exp_n = prot ? 0 : 1;
                    if (!prot) mem[a] = d;
                    n_tests++;
                    if (acks !== 3'b000) begin n_fail++; $display("FAIL rnd_write_acks: got %b expected 000", acks); end
                    n_tests++;
                    if (strobe_q.size() != exp_n) begin
                        n_fail++; $display("FAIL rnd_strobe_count: addr %h got %0d expected %0d", a, strobe_q.size(), exp_n);
                    end else if (exp_n == 1) begin
                        n_tests++;
                        if (strobe_q[0] !== {a, d}) begin
                            n_fail++; $display("FAIL rnd_strobe: got %h expected %h", strobe_q[0], {a, d});
                        end
                    end
                end
                1: begin
                    sccb_write2(a, acks2, b2, b3);
                    m_ptr = a;
                    sccb_read(got, id_ack, na_oe);
                    n_tests++;
                    if (got !== mem[m_ptr] || id_ack !== 1'b0 || na_oe !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rnd_read: addr %h got %h/ack %b/na_oe %b expected %h/0/0",
                                 m_ptr, got, id_ack, na_oe, mem[m_ptr]);
                    end
                end
                2: begin
                    sccb_read(got, id_ack, na_oe);
                    n_tests++;
                    if (got !== mem[m_ptr]) begin
                        n_fail++; $display("FAIL rnd_reread: addr %h got %h expected %h", m_ptr, got, mem[m_ptr]);
                    end
                end
                default: begin
                    peek(a, got);
                    n_tests++;
                    if (got !== mem[a]) begin
                        n_fail++; $display("FAIL rnd_peek: addr %h got %h expected %h", a, got, mem[a]);
                    end
                end
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_write3();
        test_read_pid();
        test_wrong_id();
        test_repeated_start();
        test_ro_protect();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sccb_responder
